// File: rtl/adder_pkg.sv
// Shared types for the 32-bit two-stage adder and its result collector.
package adder_pkg;

  localparam int SUM_W        = 32;
  localparam int OVF_W        = 2;
  localparam int OVF_SIGNED   = 1;
  localparam int OVF_UNSIGNED = 0;

  // One finished adder result as stored in the result FIFO.
  typedef struct packed {
    logic [OVF_W-1:0] ovf;
    logic [SUM_W-1:0] sum;
  } adder_res_t;

  localparam adder_res_t RES_ZERO = '{ovf: {OVF_W{1'b0}}, sum: {SUM_W{1'b0}}};

endpackage

// File: rtl/adder_res_fifo.sv
// Synchronous result FIFO. Push and pop in the same cycle are both honoured,
// including at full; a push at full without a pop is discarded.
module adder_res_fifo
  import adder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  adder_res_t                 push_data,
  input  logic                       pop,
  output adder_res_t                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  adder_res_t         mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_r;
  logic               full_s;
  logic               empty_s;
  logic               push_en_s;
  logic               pop_en_s;

  assign full_s  = (level_r == LVL_W'(DEPTH));
  assign empty_s = (level_r == {LVL_W{1'b0}});

  // Qualify push/pop: a full FIFO only accepts a push when it pops the same cycle.
  always_comb begin
    pop_en_s  = 1'b0;
    push_en_s = 1'b0;
    if (pop && !empty_s) begin
      pop_en_s = 1'b1;
    end else begin
      pop_en_s = 1'b0;
    end
    if (push && (!full_s || pop_en_s)) begin
      push_en_s = 1'b1;
    end else begin
      push_en_s = 1'b0;
    end
  end

  // Storage write; entries reset to zero so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RES_ZERO;
      end
    end else if (push_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_s;
  assign empty    = empty_s;
  assign level    = level_r;

endmodule

// File: rtl/adder_result_collector.sv
// Tracks real operands through the two adder stages, captures each finished
// sum once into a result FIFO, counts overflows and stalls the source.
module adder_result_collector
  import adder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue,
  input  logic                       adder_en,
  input  logic                       adder_clear,
  input  logic [SUM_W-1:0]           sum_in,
  input  logic [OVF_W-1:0]           ovf_in,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [SUM_W-1:0]           res_data,
  output logic [OVF_W-1:0]           res_ovf,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           ovf_cnt_s,
  output logic [CNT_W-1:0]           ovf_cnt_u,
  input  logic                       cnt_clr,
  output logic                       drop_err
);

  localparam int LVL_W = $clog2(DEPTH+1);

  logic               v1_r;
  logic               v2_r;
  logic               fresh_r;
  logic [CNT_W-1:0]   cnt_s_r;
  logic [CNT_W-1:0]   cnt_u_r;
  logic               drop_err_r;

  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [LVL_W-1:0]   level_s;
  logic [LVL_W:0]     stall_sum_s;
  adder_res_t         push_data_s;
  adder_res_t         head_s;

  // Saturating increment for the overflow counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Slot tags follow the adder stages; fresh marks the one cycle a sum is new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      fresh_r <= 1'b0;
    end else if (adder_en) begin
      if (adder_clear) begin
        v1_r    <= 1'b0;
        v2_r    <= 1'b0;
        fresh_r <= 1'b0;
      end else begin
        v1_r    <= issue;
        v2_r    <= v1_r;
        fresh_r <= v1_r;
      end
    end else begin
      fresh_r <= 1'b0;
    end
  end

  // fresh always implies v2 (both load from v1 together and clear together),
  // so qualifying with v2 keeps the capture tied to the stage-2 tag.
  assign push_s           = fresh_r & v2_r;
  assign pop_s            = ~empty_s & res_ready;
  assign push_data_s.ovf  = ovf_in;
  assign push_data_s.sum  = sum_in;

  adder_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level_s)
  );

  // Stall budget: stored results plus both in-flight tags must fit; pops are not credited.
  always_comb begin
    stall_sum_s = {1'b0, level_s} + {{LVL_W{1'b0}}, fresh_r} + {{LVL_W{1'b0}}, v1_r};
    if (stall_sum_s > (LVL_W+1)'(DEPTH)) begin
      stall = 1'b1;
    end else begin
      stall = 1'b0;
    end
  end

  // Overflow counters count every captured result, even one that is dropped; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_s_r <= {CNT_W{1'b0}};
      cnt_u_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cnt_s_r <= {CNT_W{1'b0}};
      cnt_u_r <= {CNT_W{1'b0}};
    end else if (push_s) begin
      if (ovf_in[OVF_SIGNED]) begin
        cnt_s_r <= sat_inc(cnt_s_r);
      end
      if (ovf_in[OVF_UNSIGNED]) begin
        cnt_u_r <= sat_inc(cnt_u_r);
      end
    end
  end

  // Sticky flag for a result lost because the FIFO was full and not popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err_r <= 1'b0;
    end else if (cnt_clr) begin
      drop_err_r <= 1'b0;
    end else if (push_s && full_s && !pop_s) begin
      drop_err_r <= 1'b1;
    end
  end

  assign res_valid = ~empty_s;
  assign res_data  = head_s.sum;
  assign res_ovf   = head_s.ovf;
  assign level     = level_s;
  assign ovf_cnt_s = cnt_s_r;
  assign ovf_cnt_u = cnt_u_r;
  assign drop_err  = drop_err_r;

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed bench for adder_result_collector. A small two-stage adder model
// feeds sum_in/ovf_in; a second instance with 2-bit counters shows saturation.
module tb_adder_result_collector;

  logic        clk;
  logic        rst_n;
  logic        issue;
  logic        adder_en;
  logic        adder_clear;
  logic [31:0] sum_in;
  logic [1:0]  ovf_in;
  logic        res_ready;
  logic        cnt_clr;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic        res_valid;
  logic [31:0] res_data;
  logic [1:0]  res_ovf;
  logic        stall;
  logic [2:0]  level;
  logic [15:0] ovf_cnt_s;
  logic [15:0] ovf_cnt_u;
  logic        drop_err;

  logic        sat_res_valid;
  logic [31:0] sat_res_data;
  logic [1:0]  sat_res_ovf;
  logic        sat_stall;
  logic [2:0]  sat_level;
  logic [1:0]  sat_cnt_s;
  logic [1:0]  sat_cnt_u;
  logic        sat_drop_err;

  int n_assert;
  int n_fail;

  adder_result_collector #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .adder_en(adder_en),
    .adder_clear(adder_clear), .sum_in(sum_in), .ovf_in(ovf_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf), .stall(stall), .level(level), .ovf_cnt_s(ovf_cnt_s),
    .ovf_cnt_u(ovf_cnt_u), .cnt_clr(cnt_clr), .drop_err(drop_err)
  );

  adder_result_collector #(.DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .issue(issue), .adder_en(adder_en),
    .adder_clear(adder_clear), .sum_in(sum_in), .ovf_in(ovf_in),
    .res_valid(sat_res_valid), .res_ready(res_ready), .res_data(sat_res_data),
    .res_ovf(sat_res_ovf), .stall(sat_stall), .level(sat_level), .ovf_cnt_s(sat_cnt_s),
    .ovf_cnt_u(sat_cnt_u), .cnt_clr(cnt_clr), .drop_err(sat_drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage adder model: stage 1 holds operands, stage 2 holds sum and flags.
  logic [31:0] s1_a_r, s1_b_r, s2_sum_r;
  logic [1:0]  s2_ovf_r;
  logic [32:0] wide_s;
  logic        sovf_s;

  always_comb begin
    wide_s = {1'b0, s1_a_r} + {1'b0, s1_b_r};
    sovf_s = (s1_a_r[31] == s1_b_r[31]) && (wide_s[31] != s1_a_r[31]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_r <= 32'h0; s1_b_r <= 32'h0; s2_sum_r <= 32'h0; s2_ovf_r <= 2'b00;
    end else if (adder_en) begin
      if (adder_clear) begin
        s1_a_r <= 32'h0; s1_b_r <= 32'h0; s2_sum_r <= 32'h0; s2_ovf_r <= 2'b00;
      end else begin
        s1_a_r   <= op_a;
        s1_b_r   <= op_b;
        s2_sum_r <= wide_s[31:0];
        s2_ovf_r <= {sovf_s, wide_s[32]};
      end
    end
  end

  assign sum_in = s2_sum_r;
  assign ovf_in = s2_ovf_r;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put_op(input logic [31:0] a, input logic [31:0] b);
    op_a  = a;
    op_b  = b;
    issue = 1'b1;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; issue = 1'b0; adder_en = 1'b0; adder_clear = 1'b0;
    res_ready = 1'b0; cnt_clr = 1'b0; op_a = 32'h0; op_b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_data", res_data, 32'h0);
    chk("rst_ovf", {30'h0, res_ovf}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_level", {29'h0, level}, 32'h0);
    chk("rst_cnt_s", {16'h0, ovf_cnt_s}, 32'h0);
    chk("rst_cnt_u", {16'h0, ovf_cnt_u}, 32'h0);
    chk("rst_drop", {31'h0, drop_err}, 32'h0);
    rst_n = 1'b1;
    step();

    // Single result: 0xFFFF + 1, pushed on the second edge after issue.
    adder_en = 1'b1;
    put_op(32'h0000_FFFF, 32'h0000_0001);
    step();
    issue = 1'b0;
    step();
    chk("t1_not_yet_valid", {31'h0, res_valid}, 32'h0);
    step();
    chk("t1_valid", {31'h0, res_valid}, 32'h1);
    chk("t1_data", res_data, 32'h0001_0000);
    chk("t1_ovf", {30'h0, res_ovf}, 32'h0);
    chk("t1_level", {29'h0, level}, 32'h1);
    res_ready = 1'b1;
    step();
    chk("t1_pop_level", {29'h0, level}, 32'h0);
    chk("t1_pop_valid", {31'h0, res_valid}, 32'h0);
    res_ready = 1'b0;

    // Signed then unsigned overflow back-to-back.
    put_op(32'h7FFF_FFFF, 32'h0000_0001);
    step();
    put_op(32'hFFFF_FFFF, 32'h0000_0001);
    step();
    issue = 1'b0;
    step();
    step();
    chk("t2_level", {29'h0, level}, 32'h2);
    chk("t2_data0", res_data, 32'h8000_0000);
    chk("t2_ovf0", {30'h0, res_ovf}, 32'h2);
    res_ready = 1'b1;
    step();
    chk("t2_data1", res_data, 32'h0000_0000);
    chk("t2_ovf1", {30'h0, res_ovf}, 32'h1);
    chk("t2_level1", {29'h0, level}, 32'h1);
    step();
    chk("t2_level0", {29'h0, level}, 32'h0);
    res_ready = 1'b0;
    chk("t2_cnt_s", {16'h0, ovf_cnt_s}, 32'h1);
    chk("t2_cnt_u", {16'h0, ovf_cnt_u}, 32'h1);
    chk("t2_sat_cnt_s", {30'h0, sat_cnt_s}, 32'h1);

    // Enable gap of 5 cycles after the issue edge: exactly one push, no duplicate.
    put_op(32'h0000_0005, 32'h0000_0006);
    step();
    adder_en = 1'b0;
    issue = 1'b0;
    repeat (5) step();
    chk("t3_gap_level", {29'h0, level}, 32'h0);
    chk("t3_gap_stall", {31'h0, stall}, 32'h0);
    adder_en = 1'b1;
    step();
    chk("t3_fresh_level", {29'h0, level}, 32'h0);
    step();
    chk("t3_push_level", {29'h0, level}, 32'h1);
    chk("t3_data", res_data, 32'h0000_000B);
    repeat (3) step();
    chk("t3_no_dup", {29'h0, level}, 32'h1);
    res_ready = 1'b1;
    step();
    chk("t3_drained", {29'h0, level}, 32'h0);
    res_ready = 1'b0;

    // Continuous issues with no consumer; source obeys stall.
    put_op(32'h0000_0100, 32'h0000_0010);
    step();
    chk("t4_stall_e1", {31'h0, stall}, 32'h0);
    put_op(32'h0000_0101, 32'h0000_0010);
    step();
    chk("t4_stall_e2", {31'h0, stall}, 32'h0);
    put_op(32'h0000_0102, 32'h0000_0010);
    step();
    chk("t4_stall_e3", {31'h0, stall}, 32'h0);
    put_op(32'h0000_0103, 32'h0000_0010);
    step();
    chk("t4_stall_at_4", {31'h0, stall}, 32'h0);
    chk("t4_level_e4", {29'h0, level}, 32'h2);
    put_op(32'hFFFF_FFFF, 32'h0000_0001);
    step();
    chk("t4_stall_on", {31'h0, stall}, 32'h1);
    chk("t4_level_e5", {29'h0, level}, 32'h3);
    adder_en = 1'b0;
    issue = 1'b0;
    step();
    chk("t4_level_peak", {29'h0, level}, 32'h4);
    chk("t4_stall_held", {31'h0, stall}, 32'h1);
    step();
    chk("t4_level_hold", {29'h0, level}, 32'h4);
    chk("t4_no_drop", {31'h0, drop_err}, 32'h0);

    // Source ignores stall: the in-flight result is dropped, counters still count.
    adder_en = 1'b1;
    put_op(32'h8000_0000, 32'h8000_0000);
    step();
    adder_en = 1'b0;
    issue = 1'b0;
    step();
    chk("t5_drop", {31'h0, drop_err}, 32'h1);
    chk("t5_level", {29'h0, level}, 32'h4);
    chk("t5_cnt_u", {16'h0, ovf_cnt_u}, 32'h2);
    chk("t5_cnt_s", {16'h0, ovf_cnt_s}, 32'h1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t5_clr_drop", {31'h0, drop_err}, 32'h0);
    chk("t5_clr_cnt_s", {16'h0, ovf_cnt_s}, 32'h0);
    chk("t5_clr_cnt_u", {16'h0, ovf_cnt_u}, 32'h0);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_drain_data", res_data, 32'h0000_0110 + 32'(i));
      step();
    end
    chk("t5_empty", {31'h0, res_valid}, 32'h0);
    res_ready = 1'b0;

    // adder_clear with v1/v2 in flight: nothing is captured afterwards.
    adder_en = 1'b1;
    adder_clear = 1'b1;
    issue = 1'b1;
    step();
    adder_clear = 1'b0;
    issue = 1'b0;
    repeat (3) step();
    chk("t6_clear_level", {29'h0, level}, 32'h0);
    chk("t6_clear_valid", {31'h0, res_valid}, 32'h0);

    // Saturation: 4 results with ovf=11; the 2-bit counters stick at 3.
    res_ready = 1'b1;
    put_op(32'h8000_0000, 32'h8000_0000);
    repeat (4) step();
    issue = 1'b0;
    chk("t7_cnt_s_2", {16'h0, ovf_cnt_s}, 32'h2);
    chk("t7_sat_s_2", {30'h0, sat_cnt_s}, 32'h2);
    chk("t7_sat_u_2", {30'h0, sat_cnt_u}, 32'h2);
    chk("t7_stream_level", {29'h0, level}, 32'h1);
    step();
    step();
    chk("t7_cnt_s_4", {16'h0, ovf_cnt_s}, 32'h4);
    chk("t7_cnt_u_4", {16'h0, ovf_cnt_u}, 32'h4);
    chk("t7_sat_s_max", {30'h0, sat_cnt_s}, 32'h3);
    chk("t7_sat_u_max", {30'h0, sat_cnt_u}, 32'h3);
    chk("t7_res_ovf", {30'h0, res_ovf}, 32'h3);
    step();
    chk("t7_drained", {29'h0, level}, 32'h0);

    // cnt_clr on the same edge as a counted push wins.
    put_op(32'h8000_0000, 32'h8000_0000);
    step();
    issue = 1'b0;
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("t8_clr_wins_s", {16'h0, ovf_cnt_s}, 32'h0);
    chk("t8_clr_wins_u", {16'h0, ovf_cnt_u}, 32'h0);
    chk("t8_pushed", {29'h0, level}, 32'h1);
    step();
    res_ready = 1'b0;

    // Reset mid-operation discards in-flight tags.
    put_op(32'h0000_0001, 32'h0000_0002);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t9_rst_level", {29'h0, level}, 32'h0);
    chk("t9_rst_stall", {31'h0, stall}, 32'h0);
    step();
    rst_n = 1'b1;
    issue = 1'b0;
    repeat (3) step();
    chk("t9_no_push", {29'h0, level}, 32'h0);
    chk("t9_no_valid", {31'h0, res_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_result_collector.md
# adder_result_collector

Downstream companion of the 32-bit two-stage pipelined adder. It tracks which adder pipeline slots hold real operands and captures each finished sum with its overflow flags exactly once into a small result FIFO. It presents results on a valid/ready port and keeps saturating signed and unsigned overflow counters. It also raises a stall toward the operand source so no in-flight result is ever lost.

## Interface
- DEPTH, 4, result FIFO entries; power of two, ≥2
- CNT_W, 16, width of each overflow counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- issue  in  1  operand pair presented to the adder this cycle is real (sampled only when adder_en=1)
- adder_en  in  1  same signal driven to the adder's enable
- adder_clear  in  1  same signal driven to the adder's clear
- sum_in  in  32  adder sum output
- ovf_in  in  2  adder overflow; [1] signed, [0] unsigned
- res_valid  out  1  FIFO non-empty
- res_ready  in  1  consumer accepts head
- res_data  out  32  FIFO head sum
- res_ovf  out  2  FIFO head overflow flags
- stall  out  1  source must hold adder_en low this cycle
- level  out  $clog2(DEPTH+1)  current FIFO occupancy
- ovf_cnt_s  out  CNT_W  count of captured results with ovf[1]=1
- ovf_cnt_u  out  CNT_W  count of captured results with ovf[0]=1
- cnt_clr  in  1  synchronous clear of counters and drop_err
- drop_err  out  1  sticky: a result arrived while FIFO full and not popping

## Operation
- Slot tracking: v1, v2 mirror adder stages. On an edge with adder_en=1, clear=0: v1<=issue, v2<=v1, fresh<=v1. With adder_en=1, clear=1: v1, v2, fresh <= 0. With adder_en=0: v1, v2 hold; fresh<=0.
- Capture: when fresh=1, {ovf_in, sum_in} is pushed on that clock edge. Each issued pair is pushed exactly once, regardless of later enable gaps.
- Pop: occurs when res_valid & res_ready. Push and pop in the same cycle are both honoured, including at full and at empty. At empty, the pushed entry is not visible until the next cycle.
- Overflow on push: if the FIFO is full and there is no pop, the entry is discarded and drop_err is set. Counters still update.
- Counters: on push, ovf_cnt_s increments if ovf_in[1] and ovf_cnt_u increments if ovf_in[0]. Both saturate at 2^CNT_W-1.
- cnt_clr clears the counters and drop_err. cnt_clr beats a simultaneous increment.
- stall = (level + fresh + v1) > DEPTH, combinational. Pops are not credited (conservative).
- adder_clear does not touch FIFO contents or counters.

## Timing
- Reset: res_valid=0, res_data=0, res_ovf=0, stall=0, level=0, both counters 0, drop_err=0, v1=v2=fresh=0. FIFO pointers are 0.
- Latency with adder_en held high: issue at edge N produces the push at edge N+2. res_valid rises after edge N+2; the result is usable in cycle N+3 of the issue.
- Each enable gap adds exactly its length in cycles.
- Throughput: one result per cycle sustained while res_ready=1.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive.
- Reset mid-operation clears everything immediately, including in-flight tags. Results still inside the adder are not captured.

## Structure
- Shared package adder_pkg: SUM_W=32, OVF_W=2, OVF_SIGNED=1, OVF_UNSIGNED=0, and the result entry struct {ovf, sum}. The adder and this block both use it.
- Sub-module adder_res_fifo: synchronous FIFO with parameter DEPTH, push/pop/full/empty/level, and same-cycle push+pop at full allowed. The top level holds the slot tracking, stall, counters and drop_err.

## Test plan
- Reset, then issue one pair at edge 1 producing 0x0000_FFFF+0x0000_0001 → res_data=0x0001_0000, res_ovf=00, res_valid high after edge 3, level=1.
- Issue 0x7FFF_FFFF+1, then 0xFFFF_FFFF+1 back-to-back → the two pops return res_ovf=10 then 01. ovf_cnt_s=1, ovf_cnt_u=1.
- Issue at edge 1, then adder_en low for 5 cycles → exactly one push, on the first enabled edge after v1 reaches stage 2; no duplicate.
- res_ready=0 with 6 continuous issues, DEPTH=4 → stall asserts when level+fresh+v1>4. No drop if the source obeys stall; level peaks at 4.
- Source ignores stall, FIFO full, no pop → drop_err=1 and level stays 4. cnt_clr → drop_err=0 and counters=0.
- Pre-load counters to 0xFFFE, then two pushes with ovf=11 → both counters stick at 0xFFFF. adder_clear with in-flight v1/v2 → no push occurs.
